vscale_hasti_arbiter: RTL and testbench

Two-master to one-slave AHB-Lite (HASTI) arbiter placed directly downstream of the core's instruction and data HASTI bridges. It merges both master ports onto a single shared slave bus, such as a unified SRAM or the system interconnect. A losing address phase is captured and its master is stalled, so neither master ever sees a dropped transfer. An uncontended transfer passes through with zero added latency.

---
 rtl/vscale_hasti_arbiter_pkg.sv | 60 ++++++
 rtl/vscale_hasti_req_buf.sv | 49 ++++
 rtl/vscale_hasti_arbiter.sv | 195 +++++++++++++++++++
 tb/tb_vscale_hasti_arbiter.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vscale_hasti_arbiter_pkg.sv
// HASTI bus constants, arbiter owner encoding and the address-phase payload shared by the arbiter files.
package vscale_hasti_arbiter_pkg;

  localparam int unsigned HASTI_ADDR_W  = 32;
  localparam int unsigned HASTI_BUS_W   = 32;
  localparam int unsigned HASTI_SIZE_W  = 3;
  localparam int unsigned HASTI_BURST_W = 3;
  localparam int unsigned HASTI_PROT_W  = 4;
  localparam int unsigned HASTI_TRANS_W = 2;

  localparam logic [HASTI_TRANS_W-1:0] HASTI_TRANS_IDLE   = 2'd0;
  localparam logic [HASTI_TRANS_W-1:0] HASTI_TRANS_BUSY   = 2'd1;
  localparam logic [HASTI_TRANS_W-1:0] HASTI_TRANS_NONSEQ = 2'd2;
  localparam logic [HASTI_TRANS_W-1:0] HASTI_TRANS_SEQ    = 2'd3;

  localparam logic [HASTI_SIZE_W-1:0]  HASTI_SIZE_WORD    = 3'd2;
  localparam logic [HASTI_BURST_W-1:0] HASTI_BURST_SINGLE = 3'd0;
  localparam logic [HASTI_PROT_W-1:0]  HASTI_PROT_DEFAULT = 4'b0011;

  localparam logic HASTI_RESP_OKAY  = 1'b0;
  localparam logic HASTI_RESP_ERROR = 1'b1;

  typedef enum logic [1:0] {
    HASTI_ARB_OWNER_NONE = 2'd0,
    HASTI_ARB_OWNER_M0   = 2'd1,
    HASTI_ARB_OWNER_M1   = 2'd2
  } hasti_arb_owner_e;

  typedef struct packed {
    logic [HASTI_ADDR_W-1:0]  haddr;
    logic                     hwrite;
    logic [HASTI_SIZE_W-1:0]  hsize;
    logic [HASTI_BURST_W-1:0] hburst;
    logic                     hmastlock;
    logic [HASTI_PROT_W-1:0]  hprot;
    logic [HASTI_TRANS_W-1:0] htrans;
  } hasti_addr_t;

  localparam hasti_addr_t HASTI_ADDR_IDLE = '{
    haddr:     '0,
    hwrite:    1'b0,
    hsize:     HASTI_SIZE_WORD,
    hburst:    HASTI_BURST_SINGLE,
    hmastlock: 1'b0,
    hprot:     HASTI_PROT_DEFAULT,
    htrans:    HASTI_TRANS_IDLE
  };

  // SEQ counts as a request (forwarded as NONSEQ); BUSY counts as idle.
  function automatic logic hasti_trans_active(input logic [HASTI_TRANS_W-1:0] trans);
    logic active;
    case (trans)
      HASTI_TRANS_NONSEQ, HASTI_TRANS_SEQ: active = 1'b1;
      HASTI_TRANS_IDLE, HASTI_TRANS_BUSY:  active = 1'b0;
      default:                             active = 1'b0;
    endcase
    return active;
  endfunction

endpackage

// File: rtl/vscale_hasti_req_buf.sv
// Per-master request detector and one-entry buffer: holds a losing address phase until it is granted.
module vscale_hasti_req_buf
  import vscale_hasti_arbiter_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  hasti_addr_t i_addr,
  input  logic        i_hready,
  input  logic        i_grant,
  output logic        o_pend,
  output logic        o_req_c,
  output hasti_addr_t o_addr_c
);

  logic        r_hready_prev;
  logic        r_pend;
  hasti_addr_t r_addr;
  logic        w_live;

  // A new address phase is only valid after the master saw hready high.
  assign w_live = hasti_trans_active(i_addr.htrans) && r_hready_prev && !r_pend;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_hready_prev <= 1'b1;
      r_pend        <= 1'b0;
      r_addr        <= HASTI_ADDR_IDLE;
    end else begin
      r_hready_prev <= i_hready;
      if (r_pend) begin
        if (i_grant) begin
          r_pend <= 1'b0;
        end
      end else if (w_live && !i_grant) begin
        r_pend <= 1'b1;
        r_addr <= i_addr;
      end
    end
  end

  always_comb begin
    o_addr_c        = r_pend ? r_addr : i_addr;
    o_addr_c.htrans = (r_pend || w_live) ? HASTI_TRANS_NONSEQ : HASTI_TRANS_IDLE;
  end

  assign o_req_c = r_pend || w_live;
  assign o_pend  = r_pend;

endmodule

// File: rtl/vscale_hasti_arbiter.sv
// Two-master (m0 = dmem, m1 = imem) to one-slave HASTI arbiter with zero-latency pass-through.
// Define VSCALE_HASTI_ARB_RR_EN for round-robin between masters instead of fixed m0 priority.
module vscale_hasti_arbiter
  import vscale_hasti_arbiter_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset,
  input  logic [HASTI_ADDR_W-1:0]  m0_haddr,
  input  logic                     m0_hwrite,
  input  logic [HASTI_SIZE_W-1:0]  m0_hsize,
  input  logic [HASTI_BURST_W-1:0] m0_hburst,
  input  logic                     m0_hmastlock,
  input  logic [HASTI_PROT_W-1:0]  m0_hprot,
  input  logic [HASTI_TRANS_W-1:0] m0_htrans,
  input  logic [HASTI_BUS_W-1:0]   m0_hwdata,
  output logic [HASTI_BUS_W-1:0]   m0_hrdata,
  output logic                     m0_hready,
  output logic                     m0_hresp,
  input  logic [HASTI_ADDR_W-1:0]  m1_haddr,
  input  logic                     m1_hwrite,
  input  logic [HASTI_SIZE_W-1:0]  m1_hsize,
  input  logic [HASTI_BURST_W-1:0] m1_hburst,
  input  logic                     m1_hmastlock,
  input  logic [HASTI_PROT_W-1:0]  m1_hprot,
  input  logic [HASTI_TRANS_W-1:0] m1_htrans,
  input  logic [HASTI_BUS_W-1:0]   m1_hwdata,
  output logic [HASTI_BUS_W-1:0]   m1_hrdata,
  output logic                     m1_hready,
  output logic                     m1_hresp,
  output logic [HASTI_ADDR_W-1:0]  s_haddr,
  output logic                     s_hwrite,
  output logic [HASTI_SIZE_W-1:0]  s_hsize,
  output logic [HASTI_BURST_W-1:0] s_hburst,
  output logic                     s_hmastlock,
  output logic [HASTI_PROT_W-1:0]  s_hprot,
  output logic [HASTI_TRANS_W-1:0] s_htrans,
  output logic [HASTI_BUS_W-1:0]   s_hwdata,
  input  logic [HASTI_BUS_W-1:0]   s_hrdata,
  input  logic                     s_hready,
  input  logic                     s_hresp
);

  hasti_addr_t      w_m0_in;
  hasti_addr_t      w_m1_in;
  hasti_addr_t      w_m0_cand;
  hasti_addr_t      w_m1_cand;
  hasti_addr_t      w_s_addr;
  logic             w_m0_req;
  logic             w_m1_req;
  logic             w_m0_pend;
  logic             w_m1_pend;
  logic             w_m0_grant;
  logic             w_m1_grant;
  hasti_arb_owner_e w_sel;
  hasti_arb_owner_e r_owner;

  assign w_m0_in = '{
    haddr:     m0_haddr,
    hwrite:    m0_hwrite,
    hsize:     m0_hsize,
    hburst:    m0_hburst,
    hmastlock: m0_hmastlock,
    hprot:     m0_hprot,
    htrans:    m0_htrans
  };

  assign w_m1_in = '{
    haddr:     m1_haddr,
    hwrite:    m1_hwrite,
    hsize:     m1_hsize,
    hburst:    m1_hburst,
    hmastlock: m1_hmastlock,
    hprot:     m1_hprot,
    htrans:    m1_htrans
  };

  vscale_hasti_req_buf u_m0_buf (
    .clk      (clk),
    .reset    (reset),
    .i_addr   (w_m0_in),
    .i_hready (m0_hready),
    .i_grant  (w_m0_grant),
    .o_pend   (w_m0_pend),
    .o_req_c  (w_m0_req),
    .o_addr_c (w_m0_cand)
  );

  vscale_hasti_req_buf u_m1_buf (
    .clk      (clk),
    .reset    (reset),
    .i_addr   (w_m1_in),
    .i_hready (m1_hready),
    .i_grant  (w_m1_grant),
    .o_pend   (w_m1_pend),
    .o_req_c  (w_m1_req),
    .o_addr_c (w_m1_cand)
  );

`ifdef VSCALE_HASTI_ARB_RR_EN
  logic r_last_m1;

  // Remembers which master was granted last; starts as m1 so m0 wins the first tie.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_last_m1 <= 1'b1;
    end else if (s_hready && (w_sel != HASTI_ARB_OWNER_NONE)) begin
      r_last_m1 <= (w_sel == HASTI_ARB_OWNER_M1);
    end
  end

  always_comb begin
    w_sel = HASTI_ARB_OWNER_NONE;
    if (w_m0_req && w_m1_req) begin
      w_sel = r_last_m1 ? HASTI_ARB_OWNER_M0 : HASTI_ARB_OWNER_M1;
    end else if (w_m0_req) begin
      w_sel = HASTI_ARB_OWNER_M0;
    end else if (w_m1_req) begin
      w_sel = HASTI_ARB_OWNER_M1;
    end
  end
`else
  // Each buffer already prefers its pending entry over its live request.
  always_comb begin
    w_sel = HASTI_ARB_OWNER_NONE;
    if (w_m0_req) begin
      w_sel = HASTI_ARB_OWNER_M0;
    end else if (w_m1_req) begin
      w_sel = HASTI_ARB_OWNER_M1;
    end
  end
`endif

  // The selection is shown on the bus every cycle but only commits while the slave is ready.
  assign w_m0_grant = s_hready && (w_sel == HASTI_ARB_OWNER_M0);
  assign w_m1_grant = s_hready && (w_sel == HASTI_ARB_OWNER_M1);

  always_comb begin
    w_s_addr = HASTI_ADDR_IDLE;
    case (w_sel)
      HASTI_ARB_OWNER_M0: w_s_addr = w_m0_cand;
      HASTI_ARB_OWNER_M1: w_s_addr = w_m1_cand;
      default:            w_s_addr = HASTI_ADDR_IDLE;
    endcase
  end

  assign s_haddr     = w_s_addr.haddr;
  assign s_hwrite    = w_s_addr.hwrite;
  assign s_hsize     = w_s_addr.hsize;
  assign s_hburst    = w_s_addr.hburst;
  assign s_hmastlock = w_s_addr.hmastlock;
  assign s_hprot     = w_s_addr.hprot;
  assign s_htrans    = w_s_addr.htrans;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_owner <= HASTI_ARB_OWNER_NONE;
    end else if (s_hready) begin
      r_owner <= w_sel;
    end
  end

  always_comb begin
    s_hwdata = '0;
    case (r_owner)
      HASTI_ARB_OWNER_M0: s_hwdata = m0_hwdata;
      HASTI_ARB_OWNER_M1: s_hwdata = m1_hwdata;
      default:            s_hwdata = '0;
    endcase
  end

  // Owner follows the slave; a master with a buffered request is stalled; otherwise free.
  always_comb begin
    m0_hready = 1'b1;
    m1_hready = 1'b1;
    if (r_owner == HASTI_ARB_OWNER_M0) begin
      m0_hready = s_hready;
    end else if (w_m0_pend) begin
      m0_hready = 1'b0;
    end
    if (r_owner == HASTI_ARB_OWNER_M1) begin
      m1_hready = s_hready;
    end else if (w_m1_pend) begin
      m1_hready = 1'b0;
    end
  end

  assign m0_hresp = ((r_owner == HASTI_ARB_OWNER_M0) && (s_hresp == HASTI_RESP_ERROR))
                    ? HASTI_RESP_ERROR : HASTI_RESP_OKAY;
  assign m1_hresp = ((r_owner == HASTI_ARB_OWNER_M1) && (s_hresp == HASTI_RESP_ERROR))
                    ? HASTI_RESP_ERROR : HASTI_RESP_OKAY;

  assign m0_hrdata = s_hrdata;
  assign m1_hrdata = s_hrdata;

endmodule

// File: tb/tb_vscale_hasti_arbiter.sv
// Directed bench for vscale_hasti_arbiter: inputs change 1 time unit after posedge, outputs sampled at negedge.
module tb_vscale_hasti_arbiter;

  logic        clk;
  logic        reset;
  logic [31:0] m0_haddr, m1_haddr, s_haddr;
  logic        m0_hwrite, m1_hwrite, s_hwrite;
  logic [2:0]  m0_hsize, m1_hsize, s_hsize;
  logic [2:0]  m0_hburst, m1_hburst, s_hburst;
  logic        m0_hmastlock, m1_hmastlock, s_hmastlock;
  logic [3:0]  m0_hprot, m1_hprot, s_hprot;
  logic [1:0]  m0_htrans, m1_htrans, s_htrans;
  logic [31:0] m0_hwdata, m1_hwdata, s_hwdata;
  logic [31:0] m0_hrdata, m1_hrdata, s_hrdata;
  logic        m0_hready, m1_hready, s_hready;
  logic        m0_hresp, m1_hresp, s_hresp;

  int errors = 0;
  int checks = 0;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] NONSEQ = 2'd2;

  vscale_hasti_arbiter dut (
    .clk(clk), .reset(reset),
    .m0_haddr(m0_haddr), .m0_hwrite(m0_hwrite), .m0_hsize(m0_hsize), .m0_hburst(m0_hburst),
    .m0_hmastlock(m0_hmastlock), .m0_hprot(m0_hprot), .m0_htrans(m0_htrans),
    .m0_hwdata(m0_hwdata), .m0_hrdata(m0_hrdata), .m0_hready(m0_hready), .m0_hresp(m0_hresp),
    .m1_haddr(m1_haddr), .m1_hwrite(m1_hwrite), .m1_hsize(m1_hsize), .m1_hburst(m1_hburst),
    .m1_hmastlock(m1_hmastlock), .m1_hprot(m1_hprot), .m1_htrans(m1_htrans),
    .m1_hwdata(m1_hwdata), .m1_hrdata(m1_hrdata), .m1_hready(m1_hready), .m1_hresp(m1_hresp),
    .s_haddr(s_haddr), .s_hwrite(s_hwrite), .s_hsize(s_hsize), .s_hburst(s_hburst),
    .s_hmastlock(s_hmastlock), .s_hprot(s_hprot), .s_htrans(s_htrans),
    .s_hwdata(s_hwdata), .s_hrdata(s_hrdata), .s_hready(s_hready), .s_hresp(s_hresp)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #4;
  endtask

  task automatic set_m0(input logic [1:0] trans, input logic [31:0] addr, input logic wr);
    m0_htrans = trans;
    m0_haddr  = addr;
    m0_hwrite = wr;
  endtask

  task automatic set_m1(input logic [1:0] trans, input logic [31:0] addr, input logic wr);
    m1_htrans = trans;
    m1_haddr  = addr;
    m1_hwrite = wr;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      next_cycle();
      set_m0(IDLE, 32'h0, 1'b0);
      set_m1(IDLE, 32'h0, 1'b0);
      m0_hwdata = 32'h0;
      m1_hwdata = 32'h0;
      s_hready  = 1'b1;
      s_hresp   = 1'b0;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    set_m0(IDLE, 32'h0, 1'b0);
    set_m1(IDLE, 32'h0, 1'b0);
    m0_hsize = 3'd2; m0_hburst = 3'd0; m0_hmastlock = 1'b0; m0_hprot = 4'b0011;
    m1_hsize = 3'd2; m1_hburst = 3'd0; m1_hmastlock = 1'b0; m1_hprot = 4'b0011;
    m0_hwdata = 32'h0; m1_hwdata = 32'h0;
    s_hrdata = 32'h0; s_hready = 1'b1; s_hresp = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    settle();
    checks++;
    if (s_htrans !== IDLE) begin errors++; $display("FAIL reset_htrans got=%0d exp=%0d", s_htrans, IDLE); end
    checks++;
    if ({m0_hready, m1_hready} !== 2'b11) begin errors++; $display("FAIL reset_hready got=%b exp=11", {m0_hready, m1_hready}); end
    checks++;
    if ({m0_hresp, m1_hresp} !== 2'b00) begin errors++; $display("FAIL reset_hresp got=%b exp=00", {m0_hresp, m1_hresp}); end
    checks++;
    if ({s_haddr, s_hwrite, s_hsize, s_hburst, s_hmastlock, s_hprot} !== {32'h0, 1'b0, 3'd2, 3'd0, 1'b0, 4'b0011}) begin
      errors++; $display("FAIL reset_idle_fields got=%h/%b/%0d/%0d/%b/%b", s_haddr, s_hwrite, s_hsize, s_hburst, s_hmastlock, s_hprot);
    end
    checks++;
    if (s_hwdata !== 32'h0) begin errors++; $display("FAIL reset_hwdata got=%h exp=0", s_hwdata); end
  endtask

  task automatic test_single_read();
    next_cycle();
    set_m1(NONSEQ, 32'h100, 1'b0);
    m1_hprot = 4'b1010;
    settle();
    checks++;
    if (s_haddr !== 32'h100) begin errors++; $display("FAIL single_haddr got=%h exp=%h", s_haddr, 32'h100); end
    checks++;
    if (s_htrans !== NONSEQ || s_hprot !== 4'b1010) begin errors++; $display("FAIL single_fields got=%0d/%b exp=2/1010", s_htrans, s_hprot); end
    next_cycle();
    set_m1(IDLE, 32'h0, 1'b0);
    m1_hprot = 4'b0011;
    s_hrdata = 32'hCAFE0100;
    settle();
    checks++;
    if (m1_hready !== 1'b1) begin errors++; $display("FAIL single_m1_hready got=%b exp=1", m1_hready); end
    checks++;
    if (m1_hrdata !== 32'hCAFE0100) begin errors++; $display("FAIL single_m1_hrdata got=%h exp=%h", m1_hrdata, 32'hCAFE0100); end
    checks++;
    if (m0_hready !== 1'b1 || m0_hrdata !== 32'hCAFE0100) begin errors++; $display("FAIL single_m0_side got=%b/%h exp=1/cafe0100", m0_hready, m0_hrdata); end
    checks++;
    if (s_htrans !== IDLE) begin errors++; $display("FAIL single_idle_after got=%0d exp=0", s_htrans); end
    idle_cycles(2);
  endtask

  task automatic test_contention();
    next_cycle();
    set_m0(NONSEQ, 32'h200, 1'b1);
    set_m1(NONSEQ, 32'h300, 1'b0);
    settle();
    checks++;
    if (s_haddr !== 32'h200 || s_hwrite !== 1'b1) begin errors++; $display("FAIL cont_first got=%h/%b exp=200/1", s_haddr, s_hwrite); end
    next_cycle();
    set_m0(IDLE, 32'h0, 1'b0);
    set_m1(IDLE, 32'h0, 1'b0);
    m0_hwdata = 32'hDEADBEEF;
    settle();
    checks++;
    if (s_haddr !== 32'h300 || s_htrans !== NONSEQ || s_hwrite !== 1'b0) begin errors++; $display("FAIL cont_second got=%h/%0d/%b exp=300/2/0", s_haddr, s_htrans, s_hwrite); end
    checks++;
    if (s_hwdata !== 32'hDEADBEEF) begin errors++; $display("FAIL cont_hwdata got=%h exp=deadbeef", s_hwdata); end
    checks++;
    if (m1_hready !== 1'b0 || m0_hready !== 1'b1) begin errors++; $display("FAIL cont_hready got=m0:%b m1:%b exp=m0:1 m1:0", m0_hready, m1_hready); end
    next_cycle();
    m0_hwdata = 32'h0;
    s_hrdata  = 32'h00003333;
    settle();
    checks++;
    if (m1_hready !== 1'b1 || m1_hrdata !== 32'h00003333) begin errors++; $display("FAIL cont_m1_done got=%b/%h exp=1/00003333", m1_hready, m1_hrdata); end
    checks++;
    if (s_htrans !== IDLE || s_hwdata !== 32'h0) begin errors++; $display("FAIL cont_tail got=%0d/%h exp=0/0", s_htrans, s_hwdata); end
    idle_cycles(2);
  endtask

  task automatic test_wait_states();
    next_cycle();
    set_m0(NONSEQ, 32'h200, 1'b0);
    set_m1(NONSEQ, 32'h300, 1'b0);
    settle();
    for (int w = 0; w < 2; w++) begin
      next_cycle();
      set_m0(IDLE, 32'h0, 1'b0);
      set_m1(IDLE, 32'h0, 1'b0);
      s_hready = 1'b0;
      settle();
      checks++;
      if (s_haddr !== 32'h300 || s_htrans !== NONSEQ) begin errors++; $display("FAIL wait_hold%0d got=%h/%0d exp=300/2", w, s_haddr, s_htrans); end
      checks++;
      if (m1_hready !== 1'b0 || m0_hready !== 1'b0) begin errors++; $display("FAIL wait_hready%0d got=m0:%b m1:%b exp=0/0", w, m0_hready, m1_hready); end
    end
    next_cycle();
    s_hready = 1'b1;
    settle();
    checks++;
    if (m0_hready !== 1'b1 || m1_hready !== 1'b0 || s_haddr !== 32'h300) begin
      errors++; $display("FAIL wait_m0_done got=m0:%b m1:%b addr=%h exp=1/0/300", m0_hready, m1_hready, s_haddr);
    end
    next_cycle();
    settle();
    checks++;
    if (m1_hready !== 1'b1 || s_htrans !== IDLE) begin errors++; $display("FAIL wait_m1_done got=%b/%0d exp=1/0", m1_hready, s_htrans); end
    idle_cycles(2);
  endtask

  task automatic test_back_to_back();
    next_cycle();
    set_m0(NONSEQ, 32'hA00, 1'b0);
    settle();
    checks++;
    if (s_haddr !== 32'hA00) begin errors++; $display("FAIL b2b_first got=%h exp=a00", s_haddr); end
    next_cycle();
    set_m0(NONSEQ, 32'hA04, 1'b0);
    s_hrdata = 32'hAAAA0000;
    settle();
    checks++;
    if (s_haddr !== 32'hA04 || m0_hready !== 1'b1 || m0_hrdata !== 32'hAAAA0000) begin
      errors++; $display("FAIL b2b_second got=%h/%b/%h exp=a04/1/aaaa0000", s_haddr, m0_hready, m0_hrdata);
    end
    next_cycle();
    set_m0(IDLE, 32'h0, 1'b0);
    s_hrdata = 32'hAAAA0004;
    settle();
    checks++;
    if (m0_hready !== 1'b1 || m0_hrdata !== 32'hAAAA0004 || s_htrans !== IDLE) begin
      errors++; $display("FAIL b2b_tail got=%b/%h/%0d exp=1/aaaa0004/0", m0_hready, m0_hrdata, s_htrans);
    end
    idle_cycles(2);
  endtask

  task automatic test_starvation();
    logic [31:0] exp_addr [4];
    int n_chk;
    exp_addr[0] = 32'h400;
`ifdef VSCALE_HASTI_ARB_RR_EN
    exp_addr[1] = 32'h500;
    exp_addr[2] = 32'h0;
    exp_addr[3] = 32'h0;
    n_chk = 2;
`else
    exp_addr[1] = 32'h404;
    exp_addr[2] = 32'h408;
    exp_addr[3] = 32'h40C;
    n_chk = 4;
`endif
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      set_m0(NONSEQ, 32'h400 + 32'(4 * i), 1'b0);
      if (i == 0) set_m1(NONSEQ, 32'h500, 1'b0);
      else        set_m1(IDLE, 32'h0, 1'b0);
      settle();
      if (i < n_chk) begin
        checks++;
        if (s_haddr !== exp_addr[i]) begin errors++; $display("FAIL starve_grant%0d got=%h exp=%h", i, s_haddr, exp_addr[i]); end
      end
      if (i > 0) begin
        checks++;
        if (m1_hready !== 1'b0) begin errors++; $display("FAIL starve_m1_stall%0d got=%b exp=0", i, m1_hready); end
      end
    end
`ifndef VSCALE_HASTI_ARB_RR_EN
    next_cycle();
    set_m0(IDLE, 32'h0, 1'b0);
    settle();
    checks++;
    if (s_haddr !== 32'h500 || m1_hready !== 1'b0) begin errors++; $display("FAIL starve_m1_grant got=%h/%b exp=500/0", s_haddr, m1_hready); end
    next_cycle();
    settle();
    checks++;
    if (m1_hready !== 1'b1) begin errors++; $display("FAIL starve_m1_done got=%b exp=1", m1_hready); end
`endif
    idle_cycles(4);
  endtask

  task automatic test_error();
    next_cycle();
    set_m0(NONSEQ, 32'h600, 1'b0);
    set_m1(NONSEQ, 32'h700, 1'b0);
    settle();
    next_cycle();
    set_m0(IDLE, 32'h0, 1'b0);
    set_m1(IDLE, 32'h0, 1'b0);
    s_hready = 1'b0;
    s_hresp  = 1'b1;
    settle();
    checks++;
    if (m0_hresp !== 1'b1 || m0_hready !== 1'b0) begin errors++; $display("FAIL err_cycle1_m0 got=%b/%b exp=1/0", m0_hresp, m0_hready); end
    checks++;
    if (m1_hresp !== 1'b0 || m1_hready !== 1'b0) begin errors++; $display("FAIL err_cycle1_m1 got=%b/%b exp=0/0", m1_hresp, m1_hready); end
    next_cycle();
    s_hready = 1'b1;
    settle();
    checks++;
    if (m0_hresp !== 1'b1 || m0_hready !== 1'b1) begin errors++; $display("FAIL err_cycle2_m0 got=%b/%b exp=1/1", m0_hresp, m0_hready); end
    checks++;
    if (m1_hresp !== 1'b0 || s_haddr !== 32'h700) begin errors++; $display("FAIL err_cycle2_m1 got=%b/%h exp=0/700", m1_hresp, s_haddr); end
    next_cycle();
    s_hresp  = 1'b0;
    s_hrdata = 32'h00007777;
    settle();
    checks++;
    if (m1_hready !== 1'b1 || m1_hrdata !== 32'h00007777 || m1_hresp !== 1'b0 || m0_hresp !== 1'b0) begin
      errors++; $display("FAIL err_m1_done got=%b/%h/%b/%b exp=1/00007777/0/0", m1_hready, m1_hrdata, m1_hresp, m0_hresp);
    end
    idle_cycles(2);
  endtask

  task automatic test_reset_midflight();
    next_cycle();
    set_m0(NONSEQ, 32'h800, 1'b1);
    set_m1(NONSEQ, 32'h900, 1'b0);
    settle();
    next_cycle();
    set_m0(IDLE, 32'h0, 1'b0);
    set_m1(IDLE, 32'h0, 1'b0);
    m0_hwdata = 32'h12345678;
    s_hready  = 1'b0;
    reset     = 1'b1;
    settle();
    checks++;
    if (m1_hready !== 1'b0 || s_hwdata !== 32'h12345678) begin errors++; $display("FAIL rst_pre got=%b/%h exp=0/12345678", m1_hready, s_hwdata); end
    next_cycle();
    reset    = 1'b0;
    s_hready = 1'b1;
    s_hresp  = 1'b1;
    settle();
    checks++;
    if (s_htrans !== IDLE) begin errors++; $display("FAIL rst_htrans got=%0d exp=0", s_htrans); end
    checks++;
    if ({m0_hready, m1_hready} !== 2'b11) begin errors++; $display("FAIL rst_hready got=%b exp=11", {m0_hready, m1_hready}); end
    checks++;
    if (s_hwdata !== 32'h0 || m0_hresp !== 1'b0) begin errors++; $display("FAIL rst_owner_none got=%h/%b exp=0/0", s_hwdata, m0_hresp); end
    next_cycle();
    s_hresp = 1'b0;
    settle();
    checks++;
    if (s_htrans !== IDLE) begin errors++; $display("FAIL rst_no_replay got=%0d exp=0", s_htrans); end
    idle_cycles(2);
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_contention();
    test_wait_states();
    test_back_to_back();
    test_starvation();
    test_error();
    test_reset_midflight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
